fft_frame_capture: RTL and testbench

//  Consumer end of the FFT output burst: after the FFT raises all_fft_done it streams N complex

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_frame_ram.sv | 24 ++
 rtl/fft_frame_capture.sv | 156 +++++++++++++++
 tb/tb_fft_frame_capture.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: frame geometry, complex sample layout and
// the bin-index bit reversal used to restore natural frequency order.
package fft_pkg;

   localparam int N_POINTS = 32;
   localparam int SAMPLE_W = 16;
   localparam int IDX_W    = $clog2(N_POINTS);

   typedef logic [IDX_W-1:0] idx_t;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] re;
      logic signed [SAMPLE_W-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2
   } cap_state_t;

   function automatic idx_t bitrev(input idx_t idx);
      idx_t r;
      for (int i = 0; i < IDX_W; i++) begin
         r[i] = idx[IDX_W-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Frame buffer: one complex sample per FFT bin, synchronous write and
// combinational read so the drain side can load its output register directly.
module fft_frame_ram
   import fft_pkg::*;
(
   input  logic  clk,
   input  logic  we,
   input  idx_t  waddr,
   input  cplx_t wdata,
   input  idx_t  raddr,
   output cplx_t rdata
);

   cplx_t mem_q [N_POINTS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_frame_capture.sv
// Captures one FFT output burst into a frame buffer, then drains it over a
// valid/ready stream, optionally reordering bit-reversed bins to natural order.
module fft_frame_capture
   import fft_pkg::*;
#(
   parameter bit BITREV = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fft_done,
   input  logic [SAMPLE_W-1:0] fft_real,
   input  logic [SAMPLE_W-1:0] fft_imag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SAMPLE_W-1:0] out_real,
   output logic [SAMPLE_W-1:0] out_imag,
   output logic [IDX_W-1:0]    out_index,
   output logic                out_last,
   output logic                busy,
   output logic                overrun
);

   localparam idx_t IDX_LAST = idx_t'(N_POINTS - 1);

   cap_state_t          state_q, state_d;
   logic                done_q;
   idx_t                wr_cnt_q, wr_cnt_d;
   idx_t                rd_cnt_q, rd_cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [SAMPLE_W-1:0] out_real_q, out_real_d;
   logic [SAMPLE_W-1:0] out_imag_q, out_imag_d;
   idx_t                out_index_q, out_index_d;
   logic                out_last_q, out_last_d;
   logic                busy_q, busy_d;
   logic                overrun_q, overrun_d;

   logic  start_s;
   logic  we_s;
   idx_t  waddr_s;
   idx_t  raddr_s;
   cplx_t wdata_s;
   cplx_t rdata_s;

   assign wdata_s = {fft_real, fft_imag};

   fft_frame_ram u_ram (
      .clk   (clk),
      .we    (we_s),
      .waddr (waddr_s),
      .wdata (wdata_s),
      .raddr (raddr_s),
      .rdata (rdata_s)
   );

   always_comb begin
      start_s     = fft_done && !done_q;
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      out_valid_d = out_valid_q;
      out_real_d  = out_real_q;
      out_imag_d  = out_imag_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
      we_s        = 1'b0;
      waddr_s     = wr_cnt_q;
      raddr_s     = BITREV ? bitrev(rd_cnt_q) : rd_cnt_q;
      // Any burst start outside IDLE is dropped and flagged, including one
      // that coincides with the final drain handshake.
      overrun_d   = overrun_q || (start_s && (state_q != ST_IDLE));

      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               we_s     = 1'b1;
               waddr_s  = idx_t'(0);
               wr_cnt_d = idx_t'(1);
               state_d  = ST_CAPTURE;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            we_s     = 1'b1;
            wr_cnt_d = wr_cnt_q + idx_t'(1);
            if (wr_cnt_q == IDX_LAST) begin
               wr_cnt_d = idx_t'(0);
               rd_cnt_d = idx_t'(0);
               state_d  = ST_DRAIN;
            end else begin
               state_d  = ST_CAPTURE;
            end
         end
         ST_DRAIN: begin
            // rd_cnt is the next bin to load; the output register refills
            // whenever it is empty or being consumed this cycle.
            if (out_valid_q && out_ready && out_last_q) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               state_d     = ST_IDLE;
            end else if (!out_valid_q || out_ready) begin
               out_valid_d = 1'b1;
               out_real_d  = rdata_s.re;
               out_imag_d  = rdata_s.im;
               out_index_d = rd_cnt_q;
               out_last_d  = (rd_cnt_q == IDX_LAST);
               rd_cnt_d    = rd_cnt_q + idx_t'(1);
            end else begin
               state_d     = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         done_q      <= 1'b0;
         wr_cnt_q    <= idx_t'(0);
         rd_cnt_q    <= idx_t'(0);
         out_valid_q <= 1'b0;
         out_real_q  <= {SAMPLE_W{1'b0}};
         out_imag_q  <= {SAMPLE_W{1'b0}};
         out_index_q <= idx_t'(0);
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_q      <= fft_done;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         out_valid_q <= out_valid_d;
         out_real_q  <= out_real_d;
         out_imag_q  <= out_imag_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_real  = out_real_q;
   assign out_imag  = out_imag_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_fft_frame_capture.sv
// Self-checking bench: one capture-order and one natural-order instance share
// stimulus; every frame's expected drain sequence is built from the driven burst.
module tb_fft_frame_capture;
   import fft_pkg::*;

   typedef struct packed {
      logic [SAMPLE_W-1:0] re;
      logic [SAMPLE_W-1:0] im;
      idx_t                idx;
      logic                last;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset;
   logic                fft_done;
   logic [SAMPLE_W-1:0] fft_real;
   logic [SAMPLE_W-1:0] fft_imag;
   logic                out_ready;
   logic                o_valid [2];
   logic                o_last  [2];
   logic                o_busy  [2];
   logic                o_ovr   [2];
   logic [SAMPLE_W-1:0] o_re    [2];
   logic [SAMPLE_W-1:0] o_im    [2];
   idx_t                o_idx   [2];

   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   start_cyc = 0;
   bit   wait_first [2];
   bit   prev_stall [2];
   exp_t prev       [2];
   bit   exp_ovr   = 1'b0;
   exp_t exp_q0 [$];
   exp_t exp_q1 [$];

   always #5 clk = ~clk;

   fft_frame_capture #(.BITREV(1'b0)) u_nat (
      .clk(clk), .reset(reset), .fft_done(fft_done), .fft_real(fft_real), .fft_imag(fft_imag),
      .out_valid(o_valid[0]), .out_ready(out_ready), .out_real(o_re[0]), .out_imag(o_im[0]),
      .out_index(o_idx[0]), .out_last(o_last[0]), .busy(o_busy[0]), .overrun(o_ovr[0])
   );

   fft_frame_capture #(.BITREV(1'b1)) u_rev (
      .clk(clk), .reset(reset), .fft_done(fft_done), .fft_real(fft_real), .fft_imag(fft_imag),
      .out_valid(o_valid[1]), .out_ready(out_ready), .out_real(o_re[1]), .out_imag(o_im[1]),
      .out_index(o_idx[1]), .out_last(o_last[1]), .busy(o_busy[1]), .overrun(o_ovr[1])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic exp_t qpop(input int d);
      return (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: ordering, content, first-sample latency and stall stability.
   always @(negedge clk) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            exp_t cur;
            exp_t e;
            cur = {o_re[d], o_im[d], o_idx[d], o_last[d]};
            if (prev_stall[d]) check($sformatf("stable_u%0d", d), cur, prev[d]);
            if (o_valid[d] && wait_first[d]) begin
               check($sformatf("latency_u%0d", d), 64'(cyc - start_cyc), 64'(N_POINTS));
               wait_first[d] = 1'b0;
            end
            if (o_valid[d]) begin
               if (qsize(d) == 0) begin
                  check($sformatf("spurious_valid_u%0d", d), 64'(1), 64'(0));
               end else if (out_ready) begin
                  e = qpop(d);
                  check($sformatf("re_u%0d_bin%0d", d, e.idx), 64'(o_re[d]), 64'(e.re));
                  check($sformatf("im_u%0d_bin%0d", d, e.idx), 64'(o_im[d]), 64'(e.im));
                  check($sformatf("index_u%0d_bin%0d", d, e.idx), 64'(o_idx[d]), 64'(e.idx));
                  check($sformatf("last_u%0d_bin%0d", d, e.idx), 64'(o_last[d]), 64'(e.last));
               end
            end
            prev_stall[d] = o_valid[d] && !out_ready;
            prev[d]       = cur;
         end
      end
   end

   // Drive one burst; mode 0 is the ramp re=k, im=-k, otherwise random data.
   task automatic burst(input int mode, input int hold);
      logic [SAMPLE_W-1:0] dr [N_POINTS];
      logic [SAMPLE_W-1:0] di [N_POINTS];
      exp_t e;
      for (int k = 0; k < N_POINTS; k++) begin
         dr[k] = (mode == 0) ? SAMPLE_W'(k)  : SAMPLE_W'($urandom);
         di[k] = (mode == 0) ? SAMPLE_W'(-k) : SAMPLE_W'($urandom);
      end
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         exp_ovr = 1'b1;
      end else begin
         for (int k = 0; k < N_POINTS; k++) begin
            e.idx  = idx_t'(k);
            e.last = (k == N_POINTS - 1);
            e.re = dr[k];
            e.im = di[k];
            exp_q0.push_back(e);
            e.re = dr[bitrev(idx_t'(k))];
            e.im = di[bitrev(idx_t'(k))];
            exp_q1.push_back(e);
         end
         start_cyc     = cyc + 1;
         wait_first[0] = 1'b1;
         wait_first[1] = 1'b1;
      end
      for (int k = 0; k < hold; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         fft_done = 1'b1;
         fft_real = (k < N_POINTS) ? dr[k] : SAMPLE_W'($urandom);
         fft_imag = (k < N_POINTS) ? di[k] : SAMPLE_W'($urandom);
      end
      @(posedge clk);
      #1;
      fft_done = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input bit rnd);
      int n = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0 || o_busy[0] || o_busy[1]) && n < 2000) begin
         @(posedge clk);
         #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      out_ready = 1'b1;
      check("drain_timeout", 64'(n >= 2000), 64'(0));
      for (int d = 0; d < 2; d++) begin
         check($sformatf("idle_valid_u%0d", d), 64'(o_valid[d]), 64'(0));
         check($sformatf("overrun_u%0d", d), 64'(o_ovr[d]), 64'(exp_ovr));
      end
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      fft_done  = 1'b0;
      fft_real  = '0;
      fft_imag  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_valid_u%0d", d), 64'(o_valid[d]), 64'(0));
         check($sformatf("rst_data_u%0d", d), 64'({o_re[d], o_im[d], o_idx[d], o_last[d]}), 64'(0));
         check($sformatf("rst_busy_u%0d", d), 64'(o_busy[d]), 64'(0));
         check($sformatf("rst_overrun_u%0d", d), 64'(o_ovr[d]), 64'(0));
      end
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Ramp, both orderings at full throughput.
      burst(0, N_POINTS);
      wait_idle(1'b0);

      // Random data with random backpressure.
      for (int r = 0; r < 3; r++) begin
         burst(1, N_POINTS);
         wait_idle(1'b1);
      end

      // fft_done held long past one frame yields a single capture.
      burst(1, 100);
      wait_idle(1'b0);

      // Second start while draining: flagged, dropped, frame 1 intact.
      burst(1, N_POINTS);
      repeat (9) @(posedge clk);
      #1;
      fork
         burst(1, N_POINTS);
         begin
            repeat (3) @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
               check($sformatf("ovr_busy_u%0d", d), 64'(o_busy[d]), 64'(1));
               check($sformatf("ovr_flag_u%0d", d), 64'(o_ovr[d]), 64'(1));
            end
         end
      join
      wait_idle(1'b0);
      burst(1, N_POINTS);
      wait_idle(1'b1);

      // Reset in the middle of draining a frame.
      burst(1, N_POINTS);
      n = 0;
      while (exp_q0.size() > N_POINTS - 5 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("reach_drain5", 64'(n >= 2000), 64'(0));
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("midrst_valid_u%0d", d), 64'(o_valid[d]), 64'(0));
         check($sformatf("midrst_busy_u%0d", d), 64'(o_busy[d]), 64'(0));
         check($sformatf("midrst_overrun_u%0d", d), 64'(o_ovr[d]), 64'(0));
         wait_first[d] = 1'b0;
         prev_stall[d] = 1'b0;
      end
      exp_q0.delete();
      exp_q1.delete();
      exp_ovr = 1'b0;
      reset   = 1'b0;
      @(posedge clk);
      #1;
      burst(0, N_POINTS);
      wait_idle(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
